knn_dist_stream: RTL

//  Front end of the k-NN classifier. On start, latches a query feature vector and streams every stored

---
 rtl/knn_pkg.sv | 20 ++
 rtl/knn_sq_diff.sv | 47 ++++
 rtl/knn_dist_stream.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// Shared k-NN constants and the distance-stream FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a; used by knn_dist_stream, k_sel and the vote stage.
package knn_pkg;

  localparam int NUM_FEAT = 8;
  localparam int FEAT_W   = 8;
  // Must match the k-nearest selector distance width.
  localparam int DIST_W   = 2*FEAT_W + $clog2(NUM_FEAT);
  // Largest possible squared distance: every feature at opposite extremes.
  localparam int unsigned MAX_DIST = NUM_FEAT * (2**FEAT_W - 1) * (2**FEAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/knn_sq_diff.sv
// One feature lane of the distance unit: |q - s| in S1, then its square in S2.
// Latency: 2 cycles from in_valid to the squared result in sq.
// Backpressure: none; registers load on their stage valid, flush clears them.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   flush          synchronous clear of both stage registers (run abort)
//   in_valid       q/s hold a live sample this cycle; loads S1
//   s1_valid       S1 holds a live sample; loads S2
//   q, s           query feature and ROM sample feature (unsigned)
//   sq             S2 register: (q - s)^2, exact
module knn_sq_diff #(
  parameter int FEAT_W = knn_pkg::FEAT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  s1_valid,
  input  logic [FEAT_W-1:0]     q,
  input  logic [FEAT_W-1:0]     s,
  output logic [2*FEAT_W-1:0]   sq
);
  import knn_pkg::*;

  logic [FEAT_W-1:0]   diff_r;
  logic [FEAT_W-1:0]   abs_diff;
  logic [2*FEAT_W-1:0] diff_wide;

  // Unsigned subtraction in whichever order keeps the result non-negative.
  assign abs_diff  = (q > s) ? (q - s) : (s - q);
  // Widen before multiplying so the product is computed at full width.
  assign diff_wide = {{FEAT_W{1'b0}}, diff_r};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      diff_r <= '0;
      sq     <= '0;
    end else if (flush) begin
      diff_r <= '0;
      sq     <= '0;
    end else begin
      if (in_valid) diff_r <= abs_diff;
      if (s1_valid) sq     <= diff_wide * diff_wide;
    end
  end

endmodule

// File: rtl/knn_dist_stream.sv
// k-NN front end: streams every ROM sample against a latched query, one squared distance per cycle.
// Latency: valid for address A appears 4 cycles after rom_rd_en for A; done 1 cycle after last valid.
// Backpressure: none; downstream must accept one beat per cycle. abort cancels and flushes.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   start, abort       run request (IDLE only) and synchronous cancel (abort wins)
//   query              query vector, feature i at [i*FEAT_W +: FEAT_W]
//   rom_rd_en/addr     sync-read ROM request; rom_data returns {class, features} one cycle later
//   valid/distance/class_out  one beat per sample, in ROM order
//   busy, done         run in progress; one-cycle completion pulse
module knn_dist_stream #(
  parameter  int NUM_FEAT    = knn_pkg::NUM_FEAT,
  parameter  int FEAT_W      = knn_pkg::FEAT_W,
  parameter  int NUM_SAMPLES = 256,
  parameter  int ADDR_W      = 8,
  localparam int DIST_W      = 2*FEAT_W + $clog2(NUM_FEAT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_FEAT*FEAT_W-1:0] query,
  output logic                       rom_rd_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [NUM_FEAT*FEAT_W:0]   rom_data,
  output logic                       valid,
  output logic [DIST_W-1:0]          distance,
  output logic                       class_out,
  output logic                       busy,
  output logic                       done
);
  import knn_pkg::*;

  localparam int                CLS_BIT   = NUM_FEAT*FEAT_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  state_t                      state, next_state;
  logic [ADDR_W-1:0]           addr_r;
  logic [NUM_FEAT*FEAT_W-1:0]  query_r;
  logic                        start_ok;
  logic                        flush;

  // Stage valid bits: v0 = rom_data live, v1 = S1, v2 = S2, v3 = S3 (output beat).
  logic                        v0, v1, v2, v3;
  // Class bit rides alongside the data through S1 and S2.
  logic                        cls1, cls2;

  logic [2*FEAT_W-1:0]         sq [NUM_FEAT];
  logic [DIST_W-1:0]           sum;

  assign start_ok = (state == IDLE) && start && !abort;
  // Abort only acts on a run in progress; in IDLE the outputs hold their last values.
  assign flush    = abort && (state != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    rom_rd_en  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) next_state = RUN;
      end
      RUN: begin
        rom_rd_en = 1'b1;
        if (abort)                 next_state = IDLE;
        else if (addr_r == LAST_ADDR) next_state = DRAIN;
      end
      DRAIN: begin
        // Leave once only S3 may still be occupied: that beat is emitted this
        // cycle, so DONE lands exactly one cycle after the final valid.
        if (abort)                  next_state = IDLE;
        else if (!(v0 || v1 || v2)) next_state = DONE;
      end
      DONE: begin
        // An abort arriving in DONE suppresses the pulse.
        done       = !abort;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------- Address counter and query register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= '0;
      query_r <= '0;
    end else begin
      // Counter advances only while staying in RUN, so it is back at 0 for the next run.
      if ((state == RUN) && (next_state == RUN)) addr_r <= addr_r + ADDR_W'(1);
      else                                       addr_r <= '0;
      if (start_ok) query_r <= query;
    end
  end

  assign rom_addr = addr_r;

  // ---------------- Feature lanes: S1 abs-diff, S2 square ----------------
  for (genvar i = 0; i < NUM_FEAT; i++) begin : g_feat
    knn_sq_diff #(.FEAT_W(FEAT_W)) u_sq_diff (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (v0),
      .s1_valid (v1),
      .q        (query_r[i*FEAT_W +: FEAT_W]),
      .s        (rom_data[i*FEAT_W +: FEAT_W]),
      .sq       (sq[i])
    );
  end

  // ---------------- S3 adder tree ----------------
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      sum = sum + DIST_W'(sq[i]);
    end
  end

  // ---------------- Valid / class pipeline and output register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      cls1      <= 1'b0;
      cls2      <= 1'b0;
      class_out <= 1'b0;
      distance  <= '0;
    end else if (flush) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      cls1      <= 1'b0;
      cls2      <= 1'b0;
      class_out <= 1'b0;
      distance  <= '0;
    end else begin
      v0 <= rom_rd_en;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      if (v0) cls1 <= rom_data[CLS_BIT];
      if (v1) cls2 <= cls1;
      if (v2) begin
        class_out <= cls2;
        distance  <= sum;
      end
    end
  end

  assign valid = v3;

endmodule
